// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencer.
// Also holds the accumulator width rule checked when the sequencer is elaborated.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFeed,
        StDrain,
        StDone
    } state_t;

    // Product register inside each MAC adds one cycle between operand and accumulate.
    localparam int unsigned MAC_PIPE_LAT = 1;

    // A DEPTH-term sum of full-width products must fit the 3*DW accumulator.
    function automatic bit acc_width_ok(input int unsigned dw, input int unsigned depth);
        return (2 * dw + $clog2(depth)) <= (3 * dw);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Control/handshake bundle between the pass controller, the sequencer and the MAC array.
// slave is the sequencer side; master is the controller/array side.
interface mac_seq_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          start;
    logic          hold;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mac_clr;
    logic          mac_en;

    modport master (
        output start,
        output hold,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_addr,
        input  mac_clr,
        input  mac_en
    );

    modport slave (
        input  start,
        input  hold,
        output busy,
        output done,
        output mem_rd_en,
        output mem_addr,
        output mac_clr,
        output mac_en
    );

endinterface

// File: rtl/valid_delay.sv
// 1-bit valid delay line of LAT stages with synchronous clear.
// empty_o looks one edge ahead: it is high when the line will hold no valid after this edge.
module valid_delay #(
    parameter int unsigned LAT = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic in_i,
    output logic out_o,
    output logic empty_o
);

    logic [LAT-1:0] dly_q, dly_d;

    if (LAT == 1) begin : g_single
        assign dly_d = in_i;
    end else begin : g_multi
        assign dly_d = {dly_q[LAT-2:0], in_i};
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign out_o   = dly_q[LAT-1];
    assign empty_o = ~|dly_d;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one matrix-vector pass over a bank of MACs: clear, stream DEPTH operand
// addresses (stallable by hold), then drain the enable pipeline and pulse done.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input logic           clk,
    input logic           rst,
    mac_seq_ctrl_if.slave bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EnLat = RD_LAT + MAC_PIPE_LAT;

    if (!acc_width_ok(DATA_WIDTH, DEPTH)) begin : g_acc_width_chk
        $error("mac_seq_ctrl: accumulator of 3*DATA_WIDTH bits can overflow for this DEPTH");
    end

    if (DEPTH < 2) begin : g_depth_chk
        $error("mac_seq_ctrl: DEPTH must be at least 2");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          clr_q, clr_d;
    logic          done_q, done_d;
    logic          last_issued;
    logic          dly_empty;
    logic          mac_en;

    // The last address went out in the current cycle, so FEED is finished.
    assign last_issued = rd_en_q && (addr_q == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StClr;
            StClr:   state_d = StFeed;
            StFeed:  if (last_issued) state_d = StDrain;
            StDrain: if (dly_empty) state_d = StDone;
            // Accepting start here lets back-to-back passes skip the idle cycle.
            StDone:  state_d = bus.start ? StClr : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        rd_en_d = (state_d == StFeed) && !bus.hold;
        addr_d  = rd_en_d ? cnt_q : '0;
        clr_d   = (state_d == StClr);
        done_d  = (state_d == StDone);
        cnt_d   = cnt_q;
        if (clr_d) begin
            cnt_d = '0;
        end else if (rd_en_d) begin
            cnt_d = (cnt_q == AW'(DEPTH - 1)) ? '0 : cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

    valid_delay #(
        .LAT (EnLat)
    ) u_en_dly (
        .clk_i   (clk),
        .clr_i   (rst),
        .in_i    (rd_en_q),
        .out_o   (mac_en),
        .empty_o (dly_empty)
    );

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mac_clr   = clr_q;
    assign bus.mac_en    = mac_en;

endmodule
